// File: rtl/sync_filter_if.sv
// Pin-side bundle for sync_filter: raw inputs and sample strobe in,
// synchronised / filtered levels and edge pulses out.
interface sync_filter_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] async_in;
  logic             sample_en;
  logic [WIDTH-1:0] sync_out;
  logic [WIDTH-1:0] filt_out;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;

  // Driver of the raw pins and the strobe (pad ring / testbench)
  modport master (
    output async_in,
    output sample_en,
    input  sync_out,
    input  filt_out,
    input  rise,
    input  fall
  );

  // The conditioner itself
  modport slave (
    input  async_in,
    input  sample_en,
    output sync_out,
    output filt_out,
    output rise,
    output fall
  );
endinterface

// File: rtl/sync_filter.sv
// Multi-bit input conditioner: STAGES-deep synchroniser per bit followed by a
// per-bit deglitch counter that only accepts a new level after FILTER_LEN
// consecutive strobed mismatches, plus registered rise/fall pulses that line
// up with the cycle in which filt_out shows the new level.
module sync_filter #(
  parameter int               WIDTH      = 1,
  parameter int               STAGES     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL  = '1,
  parameter int               FILTER_LEN = 4
) (
  input  logic          clk,
  input  logic          n_rst,
  sync_filter_if.slave  bus
);

  localparam int CNT_W = $clog2(FILTER_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic [WIDTH-1:0] stg_q [STAGES];
  logic [WIDTH-1:0] stg_d [STAGES];
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] filt_q, filt_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [WIDTH-1:0] sync_s;

  assign sync_s = stg_q[STAGES-1];

  // Synchroniser shift chain; runs every cycle, independent of sample_en
  always_comb begin
    stg_d[0] = bus.async_in;
    for (int k = 1; k < STAGES; k++) begin
      stg_d[k] = stg_q[k-1];
    end
  end

  // Per-bit deglitch: a match clears the partial count, a strobed mismatch
  // advances it, and the last strobed mismatch accepts the new level
  always_comb begin
    filt_d = filt_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync_s[i] == filt_q[i]) begin
        cnt_d[i] = CNT_ZERO;
      end else if (!bus.sample_en) begin
        cnt_d[i] = cnt_q[i];
      end else if (cnt_q[i] == CNT_LAST) begin
        cnt_d[i]  = CNT_ZERO;
        filt_d[i] = sync_s[i];
        rise_d[i] = sync_s[i];
        fall_d[i] = ~sync_s[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  // State registers; reset forces the idle level with no pending count or pulse
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int k = 0; k < STAGES; k++) begin
        stg_q[k] <= RESET_VAL;
      end
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= CNT_ZERO;
      end
      filt_q <= RESET_VAL;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        stg_q[k] <= stg_d[k];
      end
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      filt_q <= filt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign bus.sync_out = sync_s;
  assign bus.filt_out = filt_q;
  assign bus.rise     = rise_q;
  assign bus.fall     = fall_q;

endmodule

// File: tb/tb_sync_filter.sv
// Directed bench for sync_filter: a 1-bit default instance (STAGES=2,
// FILTER_LEN=4) and an 8-bit instance (STAGES=3, FILTER_LEN=4).
module tb_sync_filter;

  logic clk = 1'b0;
  logic n_rst = 1'b1;
  int   total_cnt = 0;
  int   pass_cnt = 0;

  always #5 clk = ~clk;

  sync_filter_if #(.WIDTH(1)) ifa ();
  sync_filter_if #(.WIDTH(8)) ifb ();

  sync_filter #(.WIDTH(1), .STAGES(2), .RESET_VAL(1'b1), .FILTER_LEN(4)) dut_a (
    .clk(clk), .n_rst(n_rst), .bus(ifa)
  );

  sync_filter #(.WIDTH(8), .STAGES(3), .RESET_VAL(8'hFF), .FILTER_LEN(4)) dut_b (
    .clk(clk), .n_rst(n_rst), .bus(ifb)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    logic e_filt, e_fall;
    ifa.async_in = 1'b0; ifa.sample_en = 1'b1;
    ifb.async_in = 8'hFF; ifb.sample_en = 1'b1;
    #1 n_rst = 1'b0;
    #1;
    total_cnt++;
    if (ifa.sync_out !== 1'b1) $display("FAIL reset_sync: got %b expected 1", ifa.sync_out); else pass_cnt++;
    total_cnt++;
    if (ifa.filt_out !== 1'b1) $display("FAIL reset_filt: got %b expected 1", ifa.filt_out); else pass_cnt++;
    total_cnt++;
    if ({ifa.rise, ifa.fall} !== 2'b00) $display("FAIL reset_edges: got %b expected 00", {ifa.rise, ifa.fall}); else pass_cnt++;
    total_cnt++;
    if (ifb.filt_out !== 8'hFF) $display("FAIL reset_filt_b: got %h expected ff", ifb.filt_out); else pass_cnt++;
    for (int e = 0; e < 3; e++) begin
      step(1);
      total_cnt++;
      if ({ifa.filt_out, ifa.fall} !== 2'b10) $display("FAIL reset_hold: got %b expected 10", {ifa.filt_out, ifa.fall}); else pass_cnt++;
    end
    n_rst = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      step(1);
      e_filt = (e >= 6) ? 1'b0 : 1'b1;
      e_fall = (e == 6) ? 1'b1 : 1'b0;
      total_cnt++;
      if (ifa.filt_out !== e_filt || ifa.fall !== e_fall || ifa.rise !== 1'b0)
        $display("FAIL reset_exit edge%0d: got filt=%b fall=%b rise=%b expected filt=%b fall=%b rise=0",
                 e, ifa.filt_out, ifa.fall, ifa.rise, e_filt, e_fall);
      else pass_cnt++;
    end
  endtask

  task automatic test_rise();
    logic e_sync, e_filt, e_rise;
    ifa.async_in = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      step(1);
      e_sync = (e >= 2) ? 1'b1 : 1'b0;
      e_filt = (e >= 6) ? 1'b1 : 1'b0;
      e_rise = (e == 6) ? 1'b1 : 1'b0;
      total_cnt++;
      if (ifa.sync_out !== e_sync || ifa.filt_out !== e_filt || ifa.rise !== e_rise || ifa.fall !== 1'b0)
        $display("FAIL rise edge%0d: got sync=%b filt=%b rise=%b fall=%b expected %b %b %b 0",
                 e, ifa.sync_out, ifa.filt_out, ifa.rise, ifa.fall, e_sync, e_filt, e_rise);
      else pass_cnt++;
    end
  endtask

  task automatic test_fall();
    logic e_sync, e_filt, e_fall;
    ifa.async_in = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      step(1);
      e_sync = (e >= 2) ? 1'b0 : 1'b1;
      e_filt = (e >= 6) ? 1'b0 : 1'b1;
      e_fall = (e == 6) ? 1'b1 : 1'b0;
      total_cnt++;
      if (ifa.sync_out !== e_sync || ifa.filt_out !== e_filt || ifa.fall !== e_fall || ifa.rise !== 1'b0)
        $display("FAIL fall edge%0d: got sync=%b filt=%b fall=%b rise=%b expected %b %b %b 0",
                 e, ifa.sync_out, ifa.filt_out, ifa.fall, ifa.rise, e_sync, e_filt, e_fall);
      else pass_cnt++;
    end
  endtask

  task automatic test_glitch();
    logic e_sync;
    ifa.async_in = 1'b1;
    step(8);
    total_cnt++;
    if (ifa.filt_out !== 1'b1) $display("FAIL glitch_setup: got %b expected 1", ifa.filt_out); else pass_cnt++;
    for (int e = 1; e <= 10; e++) begin
      ifa.async_in = (e >= 4) ? 1'b1 : 1'b0;
      step(1);
      e_sync = (e >= 2 && e <= 4) ? 1'b0 : 1'b1;
      total_cnt++;
      if (ifa.sync_out !== e_sync || ifa.filt_out !== 1'b1 || ifa.fall !== 1'b0)
        $display("FAIL glitch edge%0d: got sync=%b filt=%b fall=%b expected sync=%b filt=1 fall=0",
                 e, ifa.sync_out, ifa.filt_out, ifa.fall, e_sync);
      else pass_cnt++;
    end
  endtask

  task automatic test_strobe();
    logic e_filt, e_fall;
    for (int e = 1; e <= 17; e++) begin
      ifa.async_in  = 1'b0;
      ifa.sample_en = (e % 4 == 0) ? 1'b1 : 1'b0;
      step(1);
      e_filt = (e >= 16) ? 1'b0 : 1'b1;
      e_fall = (e == 16) ? 1'b1 : 1'b0;
      total_cnt++;
      if (ifa.filt_out !== e_filt || ifa.fall !== e_fall)
        $display("FAIL strobe edge%0d: got filt=%b fall=%b expected filt=%b fall=%b",
                 e, ifa.filt_out, ifa.fall, e_filt, e_fall);
      else pass_cnt++;
    end
    ifa.sample_en = 1'b1;
  endtask

  task automatic test_wide();
    logic [7:0] e_sync, e_filt, e_fall, e_rise;
    for (int e = 1; e <= 16; e++) begin
      ifb.async_in = (e == 8 || e == 9) ? 8'h5B : 8'h5A;
      step(1);
      e_sync = (e < 3) ? 8'hFF : ((e == 10 || e == 11) ? 8'h5B : 8'h5A);
      e_filt = (e >= 7) ? 8'h5A : 8'hFF;
      e_fall = (e == 7) ? 8'hA5 : 8'h00;
      total_cnt++;
      if (ifb.sync_out !== e_sync || ifb.filt_out !== e_filt || ifb.fall !== e_fall || ifb.rise !== 8'h00)
        $display("FAIL wide_fall edge%0d: got sync=%h filt=%h fall=%h rise=%h expected %h %h %h 00",
                 e, ifb.sync_out, ifb.filt_out, ifb.fall, ifb.rise, e_sync, e_filt, e_fall);
      else pass_cnt++;
    end
    ifb.async_in = 8'hFF;
    for (int e = 1; e <= 8; e++) begin
      step(1);
      e_filt = (e >= 7) ? 8'hFF : 8'h5A;
      e_rise = (e == 7) ? 8'hA5 : 8'h00;
      total_cnt++;
      if (ifb.filt_out !== e_filt || ifb.rise !== e_rise || ifb.fall !== 8'h00)
        $display("FAIL wide_rise edge%0d: got filt=%h rise=%h fall=%h expected %h %h 00",
                 e, ifb.filt_out, ifb.rise, ifb.fall, e_filt, e_rise);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_pending();
    logic e_filt, e_fall;
    // filt is 0 here; build a partial count towards 1 and reset over it
    ifa.async_in = 1'b1;
    step(4);
    #2 n_rst = 1'b0;
    #1;
    total_cnt++;
    if (ifa.filt_out !== 1'b1 || ifa.rise !== 1'b0)
      $display("FAIL rstpend_up: got filt=%b rise=%b expected filt=1 rise=0", ifa.filt_out, ifa.rise);
    else pass_cnt++;
    step(2);
    n_rst = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step(1);
      total_cnt++;
      if ({ifa.filt_out, ifa.rise, ifa.fall} !== 3'b100)
        $display("FAIL rstpend_quiet edge%0d: got filt/rise/fall=%b expected 100", e, {ifa.filt_out, ifa.rise, ifa.fall});
      else pass_cnt++;
    end
    // Partial count towards 0, then reset: sync chain must snap back at once
    ifa.async_in = 1'b0;
    step(4);
    #2 n_rst = 1'b0;
    #1;
    total_cnt++;
    if (ifa.sync_out !== 1'b1 || ifa.filt_out !== 1'b1 || ifa.fall !== 1'b0)
      $display("FAIL rstpend_down: got sync=%b filt=%b fall=%b expected 1 1 0", ifa.sync_out, ifa.filt_out, ifa.fall);
    else pass_cnt++;
    #2 n_rst = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      step(1);
      e_filt = (e >= 6) ? 1'b0 : 1'b1;
      e_fall = (e == 6) ? 1'b1 : 1'b0;
      total_cnt++;
      if (ifa.filt_out !== e_filt || ifa.fall !== e_fall || ifa.rise !== 1'b0)
        $display("FAIL rstpend_recount edge%0d: got filt=%b fall=%b rise=%b expected %b %b 0",
                 e, ifa.filt_out, ifa.fall, ifa.rise, e_filt, e_fall);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_rise();
    test_fall();
    test_glitch();
    test_strobe();
    test_wide();
    test_reset_pending();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
